// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice: per-channel
// debounce state encoding, debounce lengths and board button indices.
package btn_pkg;

    // Per-channel debounce state; the two IDLE states carry the accepted level.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    // 10 ms at 100 MHz for the board build; a short value for simulation.
    localparam int unsigned DEBOUNCE_10MS = 32'd1000000;
    localparam int unsigned SIM_DEBOUNCE  = 32'd4;

    // Bit positions inside the button vector {update, stop_f_t, start_t, start_f}.
    localparam int unsigned BTN_START_F = 32'd0;
    localparam int unsigned BTN_START_T = 32'd1;
    localparam int unsigned BTN_STOP    = 32'd2;
    localparam int unsigned BTN_UPDATE  = 32'd3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, stability counter and debounce FSM.
// The accepted level and the rise/fall pulses are all registered and change
// on the same clock edge.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    // Terminal count: the counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;

    btn_state_t             state_r;
    btn_state_t             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;

    // Synchroniser chain: the raw button enters at bit 0, the last bit is safe to use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    // Next-state logic: a level change is accepted only after the synchronised
    // input has stayed at the new value for DEBOUNCE_CYCLES consecutive cycles.
    // Pulses default to 0 so they last exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;

        case (state_r)
            IDLE_LOW: begin
                level_nxt_s = 1'b0;
                cnt_nxt_s   = CNT_ZERO;
                if (sync_s) begin
                    state_nxt_s = WAIT_HIGH;
                end else begin
                    state_nxt_s = IDLE_LOW;
                end
            end

            WAIT_HIGH: begin
                if (!sync_s) begin
                    // Excursion too short: drop it without touching the outputs.
                    state_nxt_s = IDLE_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b1;
                    rise_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end

            IDLE_HIGH: begin
                level_nxt_s = 1'b1;
                cnt_nxt_s   = CNT_ZERO;
                if (!sync_s) begin
                    state_nxt_s = WAIT_LOW;
                end else begin
                    state_nxt_s = IDLE_HIGH;
                end
            end

            WAIT_LOW: begin
                if (sync_s) begin
                    state_nxt_s = IDLE_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                    level_nxt_s = 1'b0;
                    fall_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt_s = IDLE_LOW;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    assign btn_level = level_r;
    assign btn_rise  = rise_r;
    assign btn_fall  = fall_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditioning stage for the board push-buttons {update, stop_f_t, start_t,
// start_f}: each bit is synchronised and debounced independently and offers
// a clean level plus one-cycle rise/fall pulses for direct downstream use.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 32'd4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    // Identical, independent channels; no priority between buttons.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn_in    (btn_in[i]),
            .btn_level (btn_level[i]),
            .btn_rise  (btn_rise[i]),
            .btn_fall  (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// a change sampled at edge 0 appears on the outputs at edge 6.
module tb_button_conditioner;
    import btn_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;

    int checks_r;
    int failures_r;
    int rise_cnt_r;

    button_conditioner #(
        .N_BTN           (32'd4),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE),
        .SYNC_STAGES     (32'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        rise_cnt_r = 0;
        rst        = 1'b0;
        btn_in     = 4'b0000;

        // Reset state
        settle(3);
        check_eq("rst_level", btn_level, 4'b0000);
        check_eq("rst_rise",  btn_rise,  4'b0000);
        check_eq("rst_fall",  btn_fall,  4'b0000);
        rst = 1'b1;

        // Clean press on channel 0: level/rise at edge 6, rise gone at edge 7
        btn_in = 4'b0001;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check_eq("press_level", btn_level, (e >= 6) ? 4'b0001 : 4'b0000);
            check_eq("press_rise",  btn_rise,  (e == 6) ? 4'b0001 : 4'b0000);
            check_eq("press_fall",  btn_fall,  4'b0000);
        end

        // Release channel 0
        btn_in = 4'b0000;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check_eq("rel0_level", btn_level, (e >= 6) ? 4'b0000 : 4'b0001);
            check_eq("rel0_fall",  btn_fall,  (e == 6) ? 4'b0001 : 4'b0000);
            check_eq("rel0_rise",  btn_rise,  4'b0000);
        end

        // Bounce on channel 1: 1,0,1,0 then held 1 from edge 4 -> rise at edge 10
        rise_cnt_r = 0;
        for (int e = 0; e <= 14; e++) begin
            btn_in = (e >= 4 || (e % 2) == 0) ? 4'b0010 : 4'b0000;
            tick();
            if (btn_rise[1]) rise_cnt_r++;
            check_eq("bounce_level", btn_level, (e >= 10) ? 4'b0010 : 4'b0000);
            check_eq("bounce_rise",  btn_rise,  (e == 10) ? 4'b0010 : 4'b0000);
        end
        check_eq("bounce_one_rise", 4'(rise_cnt_r), 4'd1);

        // Short glitch on channel 2 (3 cycles) while channel 1 stays held
        for (int e = 0; e <= 11; e++) begin
            btn_in = (e < 3) ? 4'b0110 : 4'b0010;
            tick();
            check_eq("glitch_level", btn_level, 4'b0010);
            check_eq("glitch_rise",  btn_rise,  4'b0000);
            check_eq("glitch_fall",  btn_fall,  4'b0000);
        end

        // Release channel 3 after a stable press
        btn_in = 4'b1010;
        settle(8);
        check_eq("ch3_pressed", btn_level, 4'b1010);
        btn_in = 4'b0010;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check_eq("rel3_level", btn_level, (e >= 6) ? 4'b0010 : 4'b1010);
            check_eq("rel3_fall",  btn_fall,  (e == 6) ? 4'b1000 : 4'b0000);
            check_eq("rel3_rise",  btn_rise,  4'b0000);
        end

        // Simultaneous press on all channels
        btn_in = 4'b0000;
        settle(8);
        check_eq("all_released", btn_level, 4'b0000);
        btn_in = 4'b1111;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check_eq("simul_rise",  btn_rise,  (e == 6) ? 4'b1111 : 4'b0000);
            check_eq("simul_level", btn_level, (e >= 6) ? 4'b1111 : 4'b0000);
        end
        btn_in = 4'b0000;
        settle(8);
        check_eq("simul_released", btn_level, 4'b0000);

        // Reset mid-operation: channel 3 accepted high, channel 0 in WAIT_HIGH with cnt=2
        btn_in = 4'b1000;
        settle(8);
        check_eq("pre_rst_level", btn_level, 4'b1000);
        btn_in = 4'b1001;
        settle(5);
        check_eq("pre_rst_wait", btn_level, 4'b1000);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_level", btn_level, 4'b0000);
        check_eq("midrst_rise",  btn_rise,  4'b0000);
        check_eq("midrst_fall",  btn_fall,  4'b0000);
        tick();
        rst = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check_eq("postrst_level", btn_level, (e >= 6) ? 4'b1001 : 4'b0000);
            check_eq("postrst_rise",  btn_rise,  (e == 6) ? 4'b1001 : 4'b0000);
            check_eq("postrst_fall",  btn_fall,  4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
